// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared definitions for the multiplier arbiter.
//   - arb_state_e : arbiter FSM states
//   - MUL_ARB_W / MUL_ARB_TIMEOUT : default operand width and watchdog limit
package mul_arb_pkg;

  localparam int MUL_ARB_W       = 16;
  localparam int MUL_ARB_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Arbitration decision for one cycle.
  typedef struct packed {
    logic vld;
    logic id;
  } grant_t;

endpackage

// File: rtl/mul_arbiter_if.sv
// mul_arbiter_if: bus between the arbiter and the shared multiplier.
//   mul_start  : one-cycle start strobe (arbiter -> multiplier)
//   mul_a/b    : operands, stable for the whole operation
//   mul_result : 2W-bit product (multiplier -> arbiter)
//   mul_done   : completion strobe
// master = arbiter side, slave = multiplier side.
interface mul_arbiter_if #(
  parameter int W = 16
) ();
  logic           mul_start;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic [2*W-1:0] mul_result;
  logic           mul_done;

  modport master (
    output mul_start, mul_a, mul_b,
    input  mul_result, mul_done
  );

  modport slave (
    input  mul_start, mul_a, mul_b,
    output mul_result, mul_done
  );
endinterface

// File: rtl/rr_pick2.sv
// rr_pick2: combinational 2-way round-robin pick.
//   req0_i, req1_i : requests
//   ptr_i          : requester that wins a tie
//   gnt_o          : {vld, id} of the winner
module rr_pick2
  import mul_arb_pkg::*;
(
  input  logic   req0_i,
  input  logic   req1_i,
  input  logic   ptr_i,
  output grant_t gnt_o
);

  always_comb begin
    gnt_o     = '0;
    gnt_o.vld = req0_i | req1_i;
    // Single request wins outright; a tie goes to the pointer.
    gnt_o.id  = (req0_i & req1_i) ? ptr_i : req1_i;
  end

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one multiplier between two requesters.
//   clk, rst        : clock, async active-low reset
//   req0/1          : requests, held until ack
//   a0,b0 / a1,b1   : operands, latched at grant
//   ack0/1          : one-cycle completion pulse
//   res_o, err_o    : product and timeout flag, valid in the ack cycle
//   busy            : FSM not in IDLE
//   mul             : master side of the multiplier bus
// Optional macro MUL_ARB_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT cycles;
// a timed-out operation completes with res_o=0, err_o=1.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int W       = MUL_ARB_W,
  parameter int TIMEOUT = MUL_ARB_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic           req1,
  input  logic [W-1:0]   a0,
  input  logic [W-1:0]   b0,
  input  logic [W-1:0]   a1,
  input  logic [W-1:0]   b1,
  output logic           ack0,
  output logic           ack1,
  output logic [2*W-1:0] res_o,
  output logic           err_o,
  output logic           busy,
  mul_arbiter_if.master  mul
);

  arb_state_e     state_q, state_d;
  logic           id_q;
  logic           ptr_q;
  logic [W-1:0]   ma_q, mb_q;
  logic [2*W-1:0] res_q;
  grant_t         gnt;
  logic           wd_exp;
  logic           resp_ent;

  rr_pick2 u_pick (
    .req0_i (req0),
    .req1_i (req1),
    .ptr_i  (ptr_q),
    .gnt_o  (gnt)
  );

  // Watchdog
`ifdef MUL_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q;
  logic            err_q;

  // Expires on the TIMEOUT-th WAIT cycle without mul_done.
  assign wd_exp = (wd_q == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == START)     wd_q <= '0;
      else if (state_q == WAIT) wd_q <= wd_q + 1'b1;
      if (resp_ent) err_q <= ~mul.mul_done;
    end
  end

  assign err_o = err_q;
`else
  assign wd_exp = 1'b0;
  assign err_o  = 1'b0;
`endif

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt.vld) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (mul.mul_done || wd_exp) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign resp_ent = (state_q == WAIT) && (state_d == RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      id_q    <= 1'b0;
      ptr_q   <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      // Operands and ID are captured only at grant, so later req/operand
      // changes cannot disturb the operation in flight.
      if (state_q == IDLE && gnt.vld) begin
        id_q <= gnt.id;
        ma_q <= gnt.id ? a1 : a0;
        mb_q <= gnt.id ? b1 : b0;
      end
      if (resp_ent) begin
        // Tie priority passes to the requester not just served.
        ptr_q <= ~id_q;
        // Done wins over a simultaneous timeout.
        res_q <= mul.mul_done ? mul.mul_result : '0;
      end
    end
  end

  assign mul.mul_start = (state_q == START);
  assign mul.mul_a     = ma_q;
  assign mul.mul_b     = mb_q;
  assign ack0          = (state_q == RESP) && !id_q;
  assign ack1          = (state_q == RESP) &&  id_q;
  assign res_o         = res_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed self-checking bench for mul_arbiter.
// The bench plays both requesters and the shared multiplier.
module tb_mul_arbiter;

  localparam int W = 16;
`ifdef MUL_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic           ack0, ack1, err_o, busy;
  logic [2*W-1:0] res_o;

  mul_arbiter_if #(.W(W)) mif ();

  mul_arbiter #(.W(W), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .req1  (req1),
    .a0    (a0),
    .b0    (b0),
    .a1    (a1),
    .b1    (b1),
    .ack0  (ack0),
    .ack1  (ack1),
    .res_o (res_o),
    .err_o (err_o),
    .busy  (busy),
    .mul   (mif)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  // Multiplier model plus cycle bookkeeping for one operation. Returns at
  // the negedge inside the cycle where the ack is expected.
  task automatic serve(input int lat, input bit chg, output int cyc,
                       output int starts, output bit early, output bit ok);
    cyc = 0; starts = 0; early = 1'b0; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(); cyc++;
      if (ack0 || ack1) early = 1'b1;
      if (mif.mul_start === 1'b1) break;
    end
    if (mif.mul_start !== 1'b1) return;
    starts = 1;
    tick(); cyc++;
    if (mif.mul_start === 1'b1) starts++;
    if (ack0 || ack1) early = 1'b1;
    for (int i = 0; i < lat; i++) begin
      if (chg && i == 0) begin a0 = '0; b0 = '0; req0 = 1'b0; end
      tick(); cyc++;
      if (mif.mul_start === 1'b1) starts++;
      if (ack0 || ack1) early = 1'b1;
    end
    mif.mul_result = 32'(mif.mul_a) * 32'(mif.mul_b);
    mif.mul_done   = 1'b1;
    tick(); cyc++;
    mif.mul_done   = 1'b0;
    ok = 1'b1;
  endtask

  task automatic test_reset();
    mif.mul_done = 1'b0; mif.mul_result = '0;
    rst = 1'b0;
    tick();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b%b want 00", ack1, ack0); end
    n_chk++; if (res_o !== '0) begin n_fail++; $display("FAIL reset_res: got %0d want 0", res_o); end
    n_chk++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_o); end
    n_chk++; if (mif.mul_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", mif.mul_start); end
    n_chk++; if (mif.mul_a !== '0 || mif.mul_b !== '0) begin n_fail++; $display("FAIL reset_ops: got %0d,%0d want 0,0", mif.mul_a, mif.mul_b); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int cyc, st; bit early, ok;
    a0 = 16'd14335; b0 = 16'd7935; req0 = 1'b1;
    serve(2, 1'b0, cyc, st, early, ok);
    req0 = 1'b0;
    n_chk++; if (!ok) begin n_fail++; $display("FAIL single_start_seen: got none want mul_start"); end
    n_chk++; if (st !== 1) begin n_fail++; $display("FAIL single_start_count: got %0d want 1", st); end
    n_chk++; if (cyc !== 5) begin n_fail++; $display("FAIL single_latency: got %0d want 5", cyc); end
    n_chk++; if (early) begin n_fail++; $display("FAIL single_early_ack: got ack before RESP want none"); end
    n_chk++; if (ack0 !== 1'b1 || ack1 !== 1'b0) begin n_fail++; $display("FAIL single_ack: got %b%b want 01", ack1, ack0); end
    n_chk++; if (res_o !== 32'd113748225) begin n_fail++; $display("FAIL single_res: got %0d want 113748225", res_o); end
    n_chk++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b want 0", err_o); end
    n_chk++; if (mif.mul_a !== 16'd14335 || mif.mul_b !== 16'd7935) begin n_fail++; $display("FAIL single_ops_stable: got %0d,%0d want 14335,7935", mif.mul_a, mif.mul_b); end
    tick();
    n_chk++; if (ack0 !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_after: got ack0=%b busy=%b want 0,0", ack0, busy); end
    n_chk++; if (res_o !== 32'd113748225) begin n_fail++; $display("FAIL single_res_hold: got %0d want 113748225", res_o); end
  endtask

  task automatic test_simul();
    int cyc, st; bit early, ok;
    do_reset();
    a0 = 16'd2; b0 = 16'd7; a1 = 16'd3; b1 = 16'd5;
    req0 = 1'b1; req1 = 1'b1;
    serve(1, 1'b0, cyc, st, early, ok);
    n_chk++; if (ack0 !== 1'b1 || ack1 !== 1'b0) begin n_fail++; $display("FAIL simul_first_ack: got %b%b want 01", ack1, ack0); end
    n_chk++; if (res_o !== 32'd14) begin n_fail++; $display("FAIL simul_first_res: got %0d want 14", res_o); end
    req0 = 1'b0;
    tick();
    n_chk++; if (busy !== 1'b0 || mif.mul_start !== 1'b0) begin n_fail++; $display("FAIL simul_gap: got busy=%b start=%b want 0,0", busy, mif.mul_start); end
    serve(0, 1'b0, cyc, st, early, ok);
    n_chk++; if (cyc !== 3 || st !== 1) begin n_fail++; $display("FAIL simul_second_timing: got cyc=%0d starts=%0d want 3,1", cyc, st); end
    n_chk++; if (ack1 !== 1'b1 || ack0 !== 1'b0) begin n_fail++; $display("FAIL simul_second_ack: got %b%b want 10", ack1, ack0); end
    n_chk++; if (res_o !== 32'd15) begin n_fail++; $display("FAIL simul_second_res: got %0d want 15", res_o); end
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_fairness();
    int cyc, st; bit early, ok;
    logic [31:0] exp_res;
    a0 = 16'd10; b0 = 16'd11; a1 = 16'd20; b1 = 16'd3;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      serve(k % 3, 1'b0, cyc, st, early, ok);
      exp_res = (k % 2 == 1) ? 32'd60 : 32'd110;
      n_chk++; if (ack0 !== (k % 2 == 0) || ack1 !== (k % 2 == 1)) begin n_fail++; $display("FAIL fair_ack_%0d: got %b%b want requester %0d", k, ack1, ack0, k % 2); end
      n_chk++; if (res_o !== exp_res) begin n_fail++; $display("FAIL fair_res_%0d: got %0d want %0d", k, res_o, exp_res); end
      n_chk++; if (cyc !== (k == 0 ? 3 : 4) + k % 3) begin n_fail++; $display("FAIL fair_cycles_%0d: got %0d want %0d", k, cyc, (k == 0 ? 3 : 4) + k % 3); end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
  endtask

  task automatic test_ignore_done();
    int n;
    mif.mul_result = 32'hDEAD; mif.mul_done = 1'b1;
    tick();
    mif.mul_done = 1'b0;
    n_chk++; if (busy !== 1'b0 || res_o !== 32'd60) begin n_fail++; $display("FAIL idle_done: got busy=%b res=%0d want 0,60", busy, res_o); end
    a1 = 16'd6; b1 = 16'd7; req1 = 1'b1;
    n = 0;
    do begin tick(); n++; end while (mif.mul_start !== 1'b1 && n < 20);
    n_chk++; if (mif.mul_start !== 1'b1) begin n_fail++; $display("FAIL ign_start: got no start want start"); end
    mif.mul_result = 32'd999; mif.mul_done = 1'b1;
    tick();
    mif.mul_done = 1'b0;
    n_chk++; if (busy !== 1'b1 || ack1 !== 1'b0) begin n_fail++; $display("FAIL start_done_ignored: got busy=%b ack1=%b want 1,0", busy, ack1); end
    tick();
    n_chk++; if (ack1 !== 1'b0) begin n_fail++; $display("FAIL wait_hold: got ack1=%b want 0", ack1); end
    mif.mul_result = 32'd42; mif.mul_done = 1'b1;
    tick();
    mif.mul_done = 1'b0;
    n_chk++; if (ack1 !== 1'b1 || res_o !== 32'd42) begin n_fail++; $display("FAIL ign_final: got ack1=%b res=%0d want 1,42", ack1, res_o); end
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_op_change();
    int cyc, st; bit early, ok;
    a0 = 16'd9; b0 = 16'd9; req0 = 1'b1;
    serve(3, 1'b1, cyc, st, early, ok);
    n_chk++; if (ack0 !== 1'b1) begin n_fail++; $display("FAIL opchg_ack: got %b want 1", ack0); end
    n_chk++; if (res_o !== 32'd81) begin n_fail++; $display("FAIL opchg_res: got %0d want 81", res_o); end
    n_chk++; if (mif.mul_a !== 16'd9) begin n_fail++; $display("FAIL opchg_mul_a: got %0d want 9", mif.mul_a); end
    tick();
  endtask

  task automatic test_mid_reset();
    int n; bit seen;
    a0 = 16'd100; b0 = 16'd100; req0 = 1'b1;
    n = 0;
    do begin tick(); n++; end while (mif.mul_start !== 1'b1 && n < 20);
    tick();
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_in_wait: got busy=%b want 1", busy); end
    rst = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0 || mif.mul_start !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin n_fail++; $display("FAIL midrst_ctl: got busy=%b start=%b ack=%b%b want 0,0,00", busy, mif.mul_start, ack1, ack0); end
    n_chk++; if (res_o !== '0 || err_o !== 1'b0 || mif.mul_a !== '0 || mif.mul_b !== '0) begin n_fail++; $display("FAIL midrst_data: got res=%0d err=%b a=%0d b=%0d want 0", res_o, err_o, mif.mul_a, mif.mul_b); end
    req0 = 1'b0;
    tick();
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ack0 || ack1 || busy) seen = 1'b1;
    end
    n_chk++; if (seen) begin n_fail++; $display("FAIL midrst_no_ack: got activity after release want none"); end
  endtask

`ifdef MUL_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n, cyc, st; bit early, ok;
    a0 = 16'd5; b0 = 16'd5; req0 = 1'b1;
    n = 0;
    do begin tick(); n++; end while (mif.mul_start !== 1'b1 && n < 20);
    n = 0;
    do begin tick(); n++; end while (ack0 !== 1'b1 && n < 40);
    req0 = 1'b0;
    n_chk++; if (n !== 9) begin n_fail++; $display("FAIL to_latency: got %0d want 9", n); end
    n_chk++; if (err_o !== 1'b1 || res_o !== '0) begin n_fail++; $display("FAIL to_flags: got err=%b res=%0d want 1,0", err_o, res_o); end
    tick();
    a1 = 16'd4; b1 = 16'd4; req1 = 1'b1;
    serve(1, 1'b0, cyc, st, early, ok);
    req1 = 1'b0;
    n_chk++; if (ack1 !== 1'b1 || err_o !== 1'b0 || res_o !== 32'd16) begin n_fail++; $display("FAIL to_recover: got ack1=%b err=%b res=%0d want 1,0,16", ack1, err_o, res_o); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_simul();
    test_fairness();
    test_ignore_done();
    test_op_change();
    test_mid_reset();
`ifdef MUL_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL have parameter W, default 16, operand width; results are 2*W bits.
REQ-002 SHALL have parameter TIMEOUT, default 64, watchdog limit in clk cycles (used only when MUL_ARB_TIMEOUT_EN is defined).
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: req0, req1  input  1 each  per-requester request, held until the matching ack.
REQ-006 SHALL have ports: a0, b0, a1, b1  input  W each  per-requester operands, sampled at grant.
REQ-007 SHALL have ports: ack0, ack1  output  1 each  one-cycle completion pulse to the requester.
REQ-008 SHALL have port: res_o  output  2W  product, valid in the ack cycle.
REQ-009 SHALL have port: err_o  output  1  timeout flag, valid in the ack cycle.
REQ-010 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-011 SHALL have ports to the shared multiplier: mul_start (output, 1), mul_a and mul_b (output, W each), mul_result (input, 2W), mul_done (input, 1).

Function
REQ-012 SHALL implement the FSM IDLE -> START -> WAIT -> RESP -> IDLE.
REQ-013 In IDLE with any req high, SHALL pick a winner, latch its operands into mul_a/mul_b and its ID, and go to START.
REQ-014 Arbitration SHALL be round-robin: with both requests high, the requester not served last wins; after reset, requester 0 has priority.
REQ-015 The priority pointer SHALL update only when RESP is entered.
REQ-016 START SHALL last exactly one cycle with mul_start=1; mul_start SHALL be 0 in all other states.
REQ-017 WAIT SHALL hold until mul_done=1, then capture mul_result into res_o and go to RESP.
REQ-018 mul_done while in IDLE or START SHALL be ignored.
REQ-019 RESP SHALL last one cycle and assert ack of the latched ID only; ack0 and ack1 SHALL never both be high.
REQ-020 res_o SHALL hold its last value until the next capture.
REQ-021 mul_a/mul_b SHALL stay stable from START until RESP.
REQ-022 Operand or req changes after grant SHALL NOT affect the operation in flight.
REQ-023 A requester that drops req before its ack SHALL still receive the ack pulse.
REQ-024 A new grant SHALL be made no earlier than the cycle after RESP, giving a minimum gap of 1 IDLE cycle between operations.
REQ-025 Latency from grant (IDLE exit) to ack SHALL be 3 + N cycles, where N is the number of WAIT cycles before mul_done.

Reset
REQ-026 When rst=0 SHALL asynchronously force: state=IDLE, mul_start=0, ack0=ack1=0, err_o=0, busy=0, res_o=0, mul_a=mul_b=0, priority pointer=0, watchdog=0.
REQ-027 Reset mid-operation SHALL abandon the operation with no ack; the multiplier is reset by the same rst.

Configuration
REQ-028 With MUL_ARB_TIMEOUT_EN defined, SHALL run a watchdog that counts WAIT cycles.
REQ-029 When the watchdog reaches TIMEOUT without mul_done, SHALL go to RESP with res_o=0 and err_o=1.
REQ-030 With MUL_ARB_TIMEOUT_EN defined, SHALL clear the watchdog on entering WAIT.
REQ-031 Without MUL_ARB_TIMEOUT_EN, WAIT SHALL wait indefinitely and err_o SHALL be tied to 0.

Structure
REQ-032 Package mul_arb_pkg SHALL hold the state enum (IDLE, START, WAIT, RESP), the default W, and the default TIMEOUT.
REQ-033 Sub-module rr_pick2 SHALL compute the 2-way round-robin winner combinationally from req0, req1 and the pointer.

Verification
REQ-034 Single request: req0 with a0=14335, b0=7935 -> one mul_start pulse; ack0 pulse with res_o=113748225; ack1 stays 0.
REQ-035 Simultaneous requests after reset: req0 and req1 high in the same cycle (a1=3, b1=5) -> requester 0 is served first, then requester 1 with res_o=15; no back-to-back grant without an IDLE cycle.
REQ-036 Fairness: req0 and req1 held continuously for 4 operations -> ack sequence is 0, 1, 0, 1.
REQ-037 Mid-operation reset: rst=0 during WAIT -> all outputs at their reset values immediately; no ack after release.
REQ-038 Timeout (macro defined, TIMEOUT=8): mul_done never asserted -> ack after 8 WAIT cycles with err_o=1 and res_o=0.
REQ-039 Operand change after grant: a0 changed to 0 while in WAIT -> res_o still equals the product of the latched operands.
